// File: rtl/uart_pkg.sv
// Shared UART receive-path types and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Deserializer bus: tick/line inputs, byte outputs, status and FSM state.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  // data_valid is a one-cycle strobe with no back-pressure: data is qualified
  // only while data_valid is high and then holds until the next good frame.
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
  rx_state_t            state;

  modport slave  (input tick, rx, output data, data_valid, frame_err, busy, state);
  modport master (output tick, rx, input data, data_valid, frame_err, busy, state);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: start detect, mid-bit sampling, stop check.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input logic clk,
  input logic rst,
  uart_rx_deserializer_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] data_q;
  logic                 dv_q, fe_q, busy_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      sh     <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      fe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      if (bus.tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              tcnt   <= '0;
              bcnt   <= '0;
              busy_q <= 1'b1;
            end
          end
          START: begin
            if (tcnt == T_HALF) begin
              tcnt <= '0;
              bcnt <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                // Line went back high before mid start bit: treat as noise.
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          DATA: begin
            if (tcnt == T_LAST) begin
              sh   <= {rx_s, sh[DATA_BITS-1:1]};
              tcnt <= '0;
              if (bcnt == B_LAST) begin
                state <= STOP;
                bcnt  <= '0;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          STOP: begin
            if (tcnt == T_LAST) begin
              tcnt <= '0;
              if (rx_s) begin
                data_q <= sh;
                dv_q   <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end else begin
                fe_q  <= 1'b1;
                state <= WAIT_HIGH;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          WAIT_HIGH: begin
            // A held-low (break) line must return high before re-arming.
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              tcnt   <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            tcnt   <= '0;
            bcnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized frame-level bench for uart_rx_deserializer with a byte scoreboard.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int W  = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_deserializer_if #(.DATA_BITS(W)) bus ();

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int fe_cnt   = 0;
  int fe_exp   = 0;
  int both_cnt = 0;
  logic [W-1:0] last_good = '0;
  int tick_div   = 4;
  int tick_count = 0;
  int phase      = 0;

  // clock / tick generation
  always #5 clk = ~clk;

  initial begin
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.tick = (phase == 0);
      if (bus.tick) tick_count++;
      phase = (phase + 1) % tick_div;
    end
  end

  // output monitor
  always @(posedge clk) begin
    #1;
    if (bus.data_valid) got_q.push_back(bus.data);
    if (bus.frame_err) fe_cnt++;
    if (bus.data_valid && bus.frame_err) both_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Each bit edge after the start edge moves by up to +/-skew ticks.
  task automatic send_frame(input logic [W-1:0] b, input bit stop_hi, input int skew);
    logic lv[10];
    int   r[11];
    lv[0] = 1'b0;
    for (int j = 0; j < W; j++) lv[j+1] = b[j];
    lv[9] = stop_hi;
    r[0]  = 0;
    r[10] = 0;
    for (int k = 1; k < 10; k++)
      r[k] = (skew > 0) ? int'($urandom_range(2 * skew, 0)) - skew : 0;
    for (int k = 0; k < 10; k++) begin
      bus.rx = lv[k];
      wait_ticks(OS + r[k+1] - r[k]);
    end
    if (stop_hi) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      fe_exp++;
    end
  endtask

  task automatic go_idle(input int n);
    bus.rx = 1'b1;
    wait_ticks(n);
  endtask

  // tests
  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", bus.data); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d expected IDLE", bus.state); end
    @(negedge clk);
    rst = 1'b0;
    go_idle(8);
  endtask

  task automatic test_good_frame();
    logic [W-1:0] e, g;
    send_frame(8'hA5, 1'b1, 0);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_busy: got %b expected 0", bus.busy); end
    for (int i = 0; i < 3; i++) begin
      go_idle(int'($urandom_range(6, 1)));
      send_frame(W'($urandom), 1'b1, 3);
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL good_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL good_data: got %h expected %h", g, e); end
    end
    total++; if (fe_cnt != fe_exp) begin bad++; $display("FAIL good_ferr: got %0d expected %0d", fe_cnt, fe_exp); end
    total++; if (bus.data !== last_good) begin bad++; $display("FAIL good_hold: got %h expected %h", bus.data, last_good); end
    exp_q.delete(); got_q.delete();
    go_idle(4);
  endtask

  task automatic test_glitch();
    bus.rx = 1'b0;
    wait_ticks(5);
    go_idle(30);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL glitch_valid: got %0d pulses expected 0", got_q.size()); end
    total++; if (fe_cnt != fe_exp) begin bad++; $display("FAIL glitch_ferr: got %0d expected %0d", fe_cnt, fe_exp); end
    total++; if (bus.data !== last_good) begin bad++; $display("FAIL glitch_data: got %h expected %h", bus.data, last_good); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b expected 0", bus.busy); end
    got_q.delete();
  endtask

  task automatic test_frame_err();
    logic [W-1:0] e, g;
    send_frame(8'h3C, 1'b0, 0);
    wait_ticks(40);
    total++; if (fe_cnt != fe_exp) begin bad++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, fe_exp); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL ferr_valid: got %0d pulses expected 0", got_q.size()); end
    total++; if (bus.data !== last_good) begin bad++; $display("FAIL ferr_data: got %h expected %h", bus.data, last_good); end
    total++; if (bus.state !== WAIT_HIGH) begin bad++; $display("FAIL ferr_hold_state: got %0d expected WAIT_HIGH", bus.state); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ferr_hold_busy: got %b expected 1", bus.busy); end
    go_idle(2);
    total++; if (bus.state !== IDLE) begin bad++; $display("FAIL ferr_rearm_state: got %0d expected IDLE", bus.state); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ferr_rearm_busy: got %b expected 0", bus.busy); end
    send_frame(W'($urandom), 1'b1, 2);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ferr_after_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL ferr_after_data: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    go_idle(4);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_frame(W'($urandom), 1'b1, 2);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_data: got %h expected %h", g, e); end
    end
    total++; if (fe_cnt != fe_exp) begin bad++; $display("FAIL b2b_ferr: got %0d expected %0d", fe_cnt, fe_exp); end
    exp_q.delete(); got_q.delete();
    go_idle(4);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] b, e, g;
    b = 8'h81;
    bus.rx = 1'b0;
    wait_ticks(OS);
    for (int j = 0; j < 4; j++) begin
      bus.rx = b[j];
      wait_ticks(OS);
    end
    bus.rx = b[4];
    wait_ticks(OS / 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h expected 00", bus.data); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", bus.data_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr: got %b expected 0", bus.frame_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    last_good = '0;
    go_idle(20);
    total++; if (got_q.size() != 0 || fe_cnt != fe_exp) begin bad++; $display("FAIL rstmid_partial: got %0d pulses/%0d ferr expected 0/%0d", got_q.size(), fe_cnt, fe_exp); end
    got_q.delete();
    send_frame(8'h55, 1'b1, 0);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_after_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rstmid_after_data: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    go_idle(4);
  endtask

  task automatic test_fast_tick();
    logic [W-1:0] e, g;
    @(negedge clk);
    tick_div = 1;
    go_idle(20);
    send_frame(8'h96, 1'b1, 0);
    total++; if (bus.data !== 8'h96) begin bad++; $display("FAIL fast_data: got %h expected 96", bus.data); end
    go_idle(3);
    send_frame(8'h96, 1'b1, 3);
    total++; if (bus.data !== 8'h96) begin bad++; $display("FAIL fast_skew_data: got %h expected 96", bus.data); end
    for (int i = 0; i < 4; i++) begin
      go_idle(int'($urandom_range(3, 0)));
      send_frame(W'($urandom), 1'b1, 3);
    end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL fast_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL fast_stream_data: got %h expected %h", g, e); end
    end
    total++; if (both_cnt != 0) begin bad++; $display("FAIL valid_ferr_overlap: got %0d overlaps expected 0", both_cnt); end
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    tick_div = 4;
    go_idle(4);
  endtask

  // sequence and final report
  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_fast_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
